// File: rtl/ps2_sender.sv
// PS/2 device-side transmitter: queues scan-code bytes in a small FIFO and
// serialises each one as an 11-bit device-to-host frame on ps2_clk/ps2_data.
module ps2_sender #(
   parameter int unsigned HALF_PERIOD = 2500,
   parameter int unsigned GAP_CYCLES  = 5000,
   parameter int unsigned FIFO_AW     = 3
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ps2_clk,
   output logic             ps2_data,
   output logic             busy,
   output logic [FIFO_AW:0] fifo_count
);

   localparam int unsigned Depth  = 1 << FIFO_AW;
   localparam int unsigned CntMax = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
   localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;

   localparam logic [CntW-1:0]  HalfLast = CntW'(HALF_PERIOD - 1);
   localparam logic [CntW-1:0]  GapLast  = CntW'(GAP_CYCLES - 1);
   localparam logic [FIFO_AW:0] Full     = (FIFO_AW + 1)'(Depth);
   localparam logic [3:0]       LastIdx  = 4'd10;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StHigh = 2'd1;
   localparam logic [1:0] StLow  = 2'd2;
   localparam logic [1:0] StGap  = 2'd3;

   logic [7:0]         mem_q [Depth];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q;
   logic               push, pop;
   logic [7:0]         rd_data;

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      idx_q, idx_d;
   logic [10:0]     frame_q, frame_d;

   logic ps2_clk_q, ps2_data_q, busy_q;

   assign in_ready   = (count_q != Full);
   assign fifo_count = count_q;
   assign push       = in_valid & in_ready;
   assign pop        = (state_q == StIdle) && (count_q != '0);
   assign rd_data    = mem_q[rd_ptr_q];

   // FIFO storage; contents need no reset since the count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at 2^FIFO_AW.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Frame sequencer: frame_q is a shift register whose bit 0 is the bit on the line.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      frame_d = frame_q;
      case (state_q)
         StIdle: begin
            if (pop) begin
               frame_d = {1'b1, ~^rd_data, rd_data, 1'b0};
               idx_d   = '0;
               cnt_d   = '0;
               state_d = StHigh;
            end
         end
         StHigh: begin
            if (cnt_q == HalfLast) begin
               cnt_d   = '0;
               state_d = StLow;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StLow: begin
            if (cnt_q == HalfLast) begin
               cnt_d = '0;
               if (idx_q == LastIdx) begin
                  state_d = StGap;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  frame_d = {1'b1, frame_q[10:1]};
                  state_d = StHigh;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            if (cnt_q == GapLast) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
      endcase
   end

   // Sequencer state registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         frame_q <= '1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
      end
   end

   // Registered line drivers, decoded from the current state so they trail it by
   // one cycle uniformly; phase lengths are unaffected.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ps2_clk_q  <= 1'b1;
         ps2_data_q <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         ps2_clk_q  <= (state_q != StLow);
         ps2_data_q <= (state_q == StHigh || state_q == StLow) ? frame_q[0] : 1'b1;
         busy_q     <= (state_q != StIdle);
      end
   end

   assign ps2_clk  = ps2_clk_q;
   assign ps2_data = ps2_data_q;
   assign busy     = busy_q;

endmodule
